// File: rtl/rc6_key_sched.sv
// RC6-32/20/16 key-schedule engine: expands a 128-bit user key into S[0..43],
// one mixing iteration per clock, result held with a level valid flag.
module rc6_key_sched #(
    parameter logic [31:0] P32      = 32'hB7E15163,
    parameter logic [31:0] Q32      = 32'h9E3779B9,
    parameter int unsigned NUM_ITER = 132
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [127:0]   i_key,
    input  logic           i_key_en,
    output logic [1407:0]  o_keyex,
    output logic           o_keyex_valid,
    output logic           o_busy
);

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] s [44];
    logic [31:0] l [4];
    logic [31:0] a, b;
    logic [5:0]  i;
    logic [1:0]  j;
    logic [7:0]  cnt;

    logic [31:0] a_new, ab_sum, b_new;
    logic        last_iter;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    assign last_iter = (cnt == 8'(NUM_ITER - 1));

    // A' feeds the B' rotate in the same cycle.
    always_comb begin
        a_new  = rol(s[i] + a + b, 5'd3);
        ab_sum = a_new + b;
        b_new  = rol(l[j] + ab_sum, ab_sum[4:0]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_key_en)
            state_next = MIX;
        else if (state == MIX && last_iter)
            state_next = DONE;
    end

    always_comb begin
        o_busy        = (state == MIX);
        o_keyex_valid = (state == DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < 44; k++) s[k] <= '0;
            for (int unsigned w = 0; w < 4; w++)  l[w] <= '0;
            a   <= '0;
            b   <= '0;
            i   <= '0;
            j   <= '0;
            cnt <= '0;
        end else if (i_key_en) begin
            for (int unsigned k = 0; k < 44; k++) s[k] <= P32 + Q32 * k;
            // Key bytes are little-endian within each 32-bit word.
            for (int unsigned w = 0; w < 4; w++)
                l[w] <= {i_key[127-32*w-24 -: 8], i_key[127-32*w-16 -: 8],
                         i_key[127-32*w-8 -: 8],  i_key[127-32*w -: 8]};
            a   <= '0;
            b   <= '0;
            i   <= '0;
            j   <= '0;
            cnt <= '0;
        end else if (state == MIX) begin
            s[i] <= a_new;
            l[j] <= b_new;
            a    <= a_new;
            b    <= b_new;
            i    <= (i == 6'd43) ? 6'd0 : i + 6'd1;
            j    <= j + 2'd1;
            cnt  <= cnt + 8'd1;
        end
    end

    always_comb begin
        o_keyex = '0;
        for (int unsigned k = 0; k < 44; k++)
            o_keyex[32*(43-k) +: 32] = s[k];
    end

endmodule

// File: tb/tb_rc6_key_sched.sv
// Self-checking bench for rc6_key_sched: latency, reference schedule,
// published RC6 cipher vectors, restart, reset and hold behaviour.
module tb_rc6_key_sched;

    logic           i_clk;
    logic           i_rst;
    logic [127:0]   i_key;
    logic           i_key_en;
    logic [1407:0]  o_keyex;
    logic           o_keyex_valid;
    logic           o_busy;

    int n_checks;
    int n_errors;

    localparam logic [127:0] KEY_B = 128'h0123456789abcdef0112233445566778;
    localparam logic [127:0] KEY_C = 128'hdeadbeef0badf00d55aa55aa13579bdf;

    rc6_key_sched dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_key         (i_key),
        .i_key_en      (i_key_en),
        .o_keyex       (o_keyex),
        .o_keyex_valid (o_keyex_valid),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [5:0] rn;
        rn = 6'd32 - {1'b0, n};
        return (x << n) | (x >> rn);
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input logic [4:0] n);
        logic [4:0] m;
        m = 5'd0 - n;
        return rol(x, m);
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] sk(input logic [1407:0] ke, input int k);
        return ke[1407-32*k -: 32];
    endfunction

    function automatic logic [1407:0] ref_sched(input logic [127:0] key);
        logic [31:0]   S [44];
        logic [31:0]   L [4];
        logic [31:0]   A, B, t;
        logic [1407:0] r;
        int            ii, jj;
        for (int w = 0; w < 4; w++)
            for (int bt = 0; bt < 4; bt++)
                L[w][8*bt +: 8] = key[127-8*(4*w+bt) -: 8];
        S[0] = 32'hB7E15163;
        for (int k = 1; k < 44; k++) S[k] = S[k-1] + 32'h9E3779B9;
        A = 0; B = 0; ii = 0; jj = 0;
        for (int n = 0; n < 132; n++) begin
            A = rol(S[ii] + A + B, 5'd3);
            S[ii] = A;
            t = A + B;
            B = rol(L[jj] + t, t[4:0]);
            L[jj] = B;
            ii = (ii + 1) % 44;
            jj = (jj + 1) % 4;
        end
        r = '0;
        for (int k = 0; k < 44; k++) r[1407-32*k -: 32] = S[k];
        return r;
    endfunction

    function automatic logic [127:0] rc6_enc(input logic [1407:0] ke, input logic [127:0] pt);
        logic [31:0] A, B, C, D, t, u, x;
        A = bswap(pt[127:96]); B = bswap(pt[95:64]);
        C = bswap(pt[63:32]);  D = bswap(pt[31:0]);
        B = B + sk(ke, 0);
        D = D + sk(ke, 1);
        for (int r = 1; r <= 20; r++) begin
            t = rol(B * (2 * B + 1), 5'd5);
            u = rol(D * (2 * D + 1), 5'd5);
            A = rol(A ^ t, u[4:0]) + sk(ke, 2*r);
            C = rol(C ^ u, t[4:0]) + sk(ke, 2*r+1);
            x = A; A = B; B = C; C = D; D = x;
        end
        A = A + sk(ke, 42);
        C = C + sk(ke, 43);
        return {bswap(A), bswap(B), bswap(C), bswap(D)};
    endfunction

    function automatic logic [127:0] rc6_dec(input logic [1407:0] ke, input logic [127:0] ct);
        logic [31:0] A, B, C, D, t, u, x;
        A = bswap(ct[127:96]); B = bswap(ct[95:64]);
        C = bswap(ct[63:32]);  D = bswap(ct[31:0]);
        C = C - sk(ke, 43);
        A = A - sk(ke, 42);
        for (int r = 20; r >= 1; r--) begin
            x = D; D = C; C = B; B = A; A = x;
            u = rol(D * (2 * D + 1), 5'd5);
            t = rol(B * (2 * B + 1), 5'd5);
            C = ror(C - sk(ke, 2*r+1), t[4:0]) ^ u;
            A = ror(A - sk(ke, 2*r), u[4:0]) ^ t;
        end
        D = D - sk(ke, 1);
        B = B - sk(ke, 0);
        return {bswap(A), bswap(B), bswap(C), bswap(D)};
    endfunction

    task automatic load_key(input logic [127:0] k);
        @(negedge i_clk);
        i_key    = k;
        i_key_en = 1'b1;
        @(negedge i_clk);
        i_key_en = 1'b0;
    endtask

    // Counts edges after the strobe until valid is seen; -1 if the budget expires.
    task automatic wait_valid(input int budget, output int cycles, output int busy_drops);
        cycles     = -1;
        busy_drops = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge i_clk);
            if (o_keyex_valid === 1'b1) begin
                cycles = n;
                break;
            end
            if (o_busy !== 1'b1) busy_drops++;
        end
    endtask

    task automatic test_reset;
        logic bad;
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_keyex !== '0 || o_keyex_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: keyex_nonzero=%0b valid=%b busy=%b, required 0/0/0",
                     |o_keyex, o_keyex_valid, o_busy);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        bad = 1'b0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_keyex !== '0 || o_keyex_valid !== 1'b0 || o_busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_hold: outputs changed=%b, required 0", bad);
        end
    endtask

    task automatic test_zero_key;
        int cyc, drops;
        logic [127:0] ct;
        load_key('0);
        n_checks++;
        if (o_busy !== 1'b1 || o_keyex_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_after_strobe: busy=%b valid=%b, required 1/0", o_busy, o_keyex_valid);
        end
        wait_valid(300, cyc, drops);
        n_checks++;
        if (cyc !== 132) begin
            n_errors++;
            $display("FAIL zero_latency: valid after %0d edges, required 132", cyc);
        end
        n_checks++;
        if (drops !== 0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_busy: busy low %0d times in MIX, busy at done=%b, required 0/0",
                     drops, o_busy);
        end
        n_checks++;
        if (o_keyex !== ref_sched('0)) begin
            n_errors++;
            $display("FAIL zero_schedule: S0=%h S43=%h, required S0=%h S43=%h",
                     sk(o_keyex, 0), sk(o_keyex, 43), sk(ref_sched('0), 0), sk(ref_sched('0), 43));
        end
        ct = rc6_enc(o_keyex, '0);
        n_checks++;
        if (ct !== 128'h8fc3a53656b1f778c129df4e9848a41e) begin
            n_errors++;
            $display("FAIL zero_encrypt: got %h, required 8fc3a53656b1f778c129df4e9848a41e", ct);
        end
    endtask

    task automatic test_second_key;
        int cyc, drops;
        logic [127:0] ct, pt;
        load_key(KEY_B);
        wait_valid(300, cyc, drops);
        n_checks++;
        if (cyc !== 132) begin
            n_errors++;
            $display("FAIL key2_latency: valid after %0d edges, required 132", cyc);
        end
        ct = rc6_enc(o_keyex, 128'h02132435465768798a9bacbdcedfe0f1);
        n_checks++;
        if (ct !== 128'h524e192f4715c6231f51f6367ea43f18) begin
            n_errors++;
            $display("FAIL key2_encrypt: got %h, required 524e192f4715c6231f51f6367ea43f18", ct);
        end
        pt = rc6_dec(o_keyex, 128'h524e192f4715c6231f51f6367ea43f18);
        n_checks++;
        if (pt !== 128'h02132435465768798a9bacbdcedfe0f1) begin
            n_errors++;
            $display("FAIL key2_decrypt: got %h, required 02132435465768798a9bacbdcedfe0f1", pt);
        end
    endtask

    task automatic test_restart;
        int cyc, drops;
        logic early;
        load_key(KEY_C);
        early = 1'b0;
        repeat (59) begin
            @(negedge i_clk);
            if (o_keyex_valid !== 1'b0) early = 1'b1;
        end
        load_key(KEY_B);
        n_checks++;
        if (early !== 1'b0 || o_keyex_valid !== 1'b0 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_abort: early_valid=%b valid=%b busy=%b, required 0/0/1",
                     early, o_keyex_valid, o_busy);
        end
        wait_valid(300, cyc, drops);
        n_checks++;
        if (cyc !== 132) begin
            n_errors++;
            $display("FAIL restart_latency: valid after %0d edges, required 132", cyc);
        end
        n_checks++;
        if (o_keyex !== ref_sched(KEY_B)) begin
            n_errors++;
            $display("FAIL restart_schedule: S0=%h, required %h", sk(o_keyex, 0), sk(ref_sched(KEY_B), 0));
        end
    endtask

    task automatic test_reset_mid_mix;
        int cyc, drops;
        logic seen;
        load_key(KEY_C);
        repeat (99) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_keyex !== '0 || o_keyex_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_values: keyex_nonzero=%0b valid=%b busy=%b, required 0/0/0",
                     |o_keyex, o_keyex_valid, o_busy);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 1'b0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_keyex_valid !== 1'b0 || o_busy !== 1'b0 || o_keyex !== '0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_no_resume: activity=%b, required 0", seen);
        end
        load_key(KEY_C);
        wait_valid(300, cyc, drops);
        n_checks++;
        if (cyc !== 132 || o_keyex !== ref_sched(KEY_C)) begin
            n_errors++;
            $display("FAIL midreset_reload: latency %0d S0=%h, required 132 S0=%h",
                     cyc, sk(o_keyex, 0), sk(ref_sched(KEY_C), 0));
        end
    endtask

    task automatic test_hold_done;
        logic [1407:0] snap;
        logic bad;
        snap = o_keyex;
        bad  = 1'b0;
        repeat (1000) begin
            @(negedge i_clk);
            if (o_keyex !== snap || o_keyex_valid !== 1'b1 || o_busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0 || o_keyex !== ref_sched(KEY_C)) begin
            n_errors++;
            $display("FAIL hold_done: changed=%b S0=%h, required 0 S0=%h",
                     bad, sk(o_keyex, 0), sk(ref_sched(KEY_C), 0));
        end
        load_key('0);
        n_checks++;
        if (o_keyex_valid !== 1'b0 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_restrobe: valid=%b busy=%b, required 0/1", o_keyex_valid, o_busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_key    = '0;
        i_key_en = 1'b0;
        i_rst    = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        test_reset;
        test_zero_key;
        test_second_key;
        test_restart;
        test_reset_mid_mix;
        test_hold_done;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
